// File: rtl/sqrt_scheduler.sv
// Shared bit-serial square-root engine with two-port round-robin arbitration.
// Produces floor(sqrt(operand * 2^OUT_W)) one result bit per cycle, tagged with the requester ID.
module sqrt_scheduler #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16,
    parameter int CMP_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [IN_W-1:0]  in0,
    output logic             gnt0,
    input  logic             req1,
    input  logic [IN_W-1:0]  in1,
    output logic             gnt1,
    output logic             busy,
    output logic             out_valid,
    output logic             out_id,
    output logic [OUT_W-1:0] out
);

    localparam int BIT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [0:0] {IDLE, CALC} state_t;

    state_t             state_q, state_d;
    logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic               out_valid_q, out_valid_d;
    logic               out_id_q, out_id_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               last_q, last_d;
    logic               id_q, id_d;
    logic [CMP_W-1:0]   opnd_q, opnd_d;
    logic [OUT_W-1:0]   root_q, root_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               win;
    logic [IN_W-1:0]    in_sel;
    logic [OUT_W-1:0]   trial;

    // Full-width square compare; CMP_W is wide enough that nothing is truncated.
    function automatic logic fits(input logic [OUT_W-1:0] t, input logic [CMP_W-1:0] s);
        logic [CMP_W-1:0] sq;
        sq = CMP_W'(t) * CMP_W'(t);
        return sq <= s;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_q       <= '0;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_q       <= out_d;
            last_q      <= last_d;
            id_q        <= id_d;
        end
    end

    always_ff @(posedge clk) begin
        opnd_q <= opnd_d;
        root_q <= root_d;
        bit_q  <= bit_d;
    end

    always_comb begin
        state_d     = state_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        out_valid_d = 1'b0;
        out_id_d    = out_id_q;
        out_d       = out_q;
        last_d      = last_q;
        id_d        = id_q;
        opnd_d      = opnd_q;
        root_d      = root_q;
        bit_d       = bit_q;
        win         = 1'b0;
        in_sel      = in0;
        trial       = '0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // On contention the port not served last wins.
                    win     = (req0 && req1) ? ~last_q : req1;
                    in_sel  = win ? in1 : in0;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    opnd_d  = CMP_W'(in_sel) << OUT_W;
                    root_d  = '0;
                    bit_d   = BIT_W'(OUT_W - 1);
                    id_d    = win;
                    state_d = CALC;
                end
            end
            CALC: begin
                trial = root_q | (OUT_W'(1) << bit_q);
                if (fits(trial, opnd_q)) begin
                    root_d = trial;
                end
                if (bit_q == '0) begin
                    out_d       = root_d;
                    out_id_d    = id_q;
                    out_valid_d = 1'b1;
                    last_d      = id_q;
                    state_d     = IDLE;
                end else begin
                    bit_d = bit_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == CALC);
        gnt0      = gnt0_q;
        gnt1      = gnt1_q;
        out_valid = out_valid_q;
        out_id    = out_id_q;
        out       = out_q;
    end

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Directed bench for sqrt_scheduler: latency, arbitration order, output hold, reset abort,
// and a full operand sweep against a brute-force square-root model.
module tb_sqrt_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  in0 = '0, in1 = '0;
    logic        gnt0, gnt1, busy, out_valid, out_id;
    logic [15:0] out;

    int n_cmp = 0;
    int n_bad = 0;

    sqrt_scheduler #(.IN_W(8), .OUT_W(16), .CMP_W(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .in0(in0), .gnt0(gnt0),
        .req1(req1), .in1(in1), .gnt1(gnt1),
        .busy(busy), .out_valid(out_valid), .out_id(out_id), .out(out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int ref_sqrt(input int v);
        longint n;
        longint r;
        n = longint'(v) << 16;
        r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        return int'(r);
    endfunction

    always @(negedge clk) begin
        if (!rst) chk("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_job(input bit port, input logic [7:0] val, input int exp, input string tag);
        bit got;
        int cyc, bcnt;
        if (port) begin req1 = 1'b1; in1 = val; end
        else      begin req0 = 1'b1; in0 = val; end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (port ? gnt1 : gnt0) got = 1;
        end
        chk({tag, "_gnt"}, {31'd0, got}, 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        if (!got) return;
        bcnt = busy ? 1 : 0;
        cyc  = 0;
        got  = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (out_valid) got = 1;
            else if (busy) bcnt++;
        end
        chk({tag, "_lat"},  cyc, 16);
        chk({tag, "_busy"}, bcnt, 16);
        chk({tag, "_out"},  {16'd0, out}, exp);
        chk({tag, "_id"},   {31'd0, out_id}, {31'd0, port});
    endtask

    task automatic wait_valid(output bit got);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
    endtask

    initial begin
        bit got, seen;
        int wcyc, vcnt, exp_id;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_gnt0", {31'd0, gnt0}, 0);
        chk("rst_gnt1", {31'd0, gnt1}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_vld",  {31'd0, out_valid}, 0);
        chk("rst_id",   {31'd0, out_id}, 0);
        chk("rst_out",  {16'd0, out}, 0);

        run_job(1'b0, 8'd4,   32'h0200, "p0_4");
        run_job(1'b1, 8'd0,   32'h0000, "p1_0");
        run_job(1'b1, 8'd1,   32'h0100, "p1_1");
        run_job(1'b1, 8'd2,   32'h016A, "p1_2");
        run_job(1'b1, 8'd255, 32'h0FF7, "p1_255");

        // Contention after reset: 0,1,0,1 with one-cycle gap after each result
        do_reset();
        in0 = 8'd9; in1 = 8'd16; req0 = 1'b1; req1 = 1'b1;
        exp_id = 0;
        for (int k = 0; k < 4; k++) begin
            got = 0; wcyc = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                wcyc++;
                if (gnt0 | gnt1) got = 1;
            end
            chk("cont_gnt", {31'd0, got}, 1);
            chk("cont_order", {31'd0, gnt1}, exp_id);
            if (k > 0) chk("cont_gap", wcyc, 1);
            wait_valid(got);
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
            chk("cont_vld", {31'd0, got}, 1);
            chk("cont_out", {16'd0, out}, (exp_id != 0) ? 32'h0400 : 32'h0300);
            chk("cont_id", {31'd0, out_id}, exp_id);
            exp_id ^= 1;
        end

        // req1 raised mid-CALC of a port-0 job
        @(negedge clk);
        req0 = 1'b1; in0 = 8'd4;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (gnt0) got = 1;
        end
        chk("mid_gnt0", {31'd0, got}, 1);
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        req1 = 1'b1; in1 = 8'd1;
        seen = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (gnt1) seen = 1;
            if (out_valid) got = 1;
        end
        chk("mid_nogrant", {31'd0, seen}, 0);
        chk("mid_out0", {16'd0, out}, 32'h0200);
        chk("mid_id0", {31'd0, out_id}, 0);
        @(negedge clk);
        chk("mid_gnt1", {31'd0, gnt1}, 1);
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_hold", {16'd0, out}, 32'h0200);
        chk("mid_hold_vld", {31'd0, out_valid}, 0);
        wait_valid(got);
        chk("mid_vld1", {31'd0, got}, 1);
        chk("mid_out1", {16'd0, out}, 32'h0100);
        chk("mid_id1", {31'd0, out_id}, 1);

        // Reset 8 cycles into CALC aborts the job
        @(negedge clk);
        req1 = 1'b1; in1 = 8'd255;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (gnt1) got = 1;
        end
        chk("abort_gnt", {31'd0, got}, 1);
        req1 = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_out",  {16'd0, out}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_id",   {31'd0, out_id}, 0);
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) vcnt++;
        end
        chk("abort_novld", vcnt, 0);
        run_job(1'b1, 8'd2, 32'h016A, "post_p1");
        in0 = 8'd1; in1 = 8'd0; req0 = 1'b1; req1 = 1'b1;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (gnt0 | gnt1) got = 1;
        end
        chk("post_both_gnt0", {31'd0, gnt0}, 1);
        req0 = 1'b0; req1 = 1'b0;
        wait_valid(got);
        chk("post_both_out", {16'd0, out}, 32'h0100);
        chk("post_both_id", {31'd0, out_id}, 0);

        // Reset in the same edge as a request wins
        @(negedge clk);
        rst = 1'b1; req0 = 1'b1; in0 = 8'd4;
        @(negedge clk);
        chk("rst_req_gnt", {31'd0, gnt0}, 0);
        chk("rst_req_busy", {31'd0, busy}, 0);
        rst = 1'b0; req0 = 1'b0;
        @(negedge clk);
        chk("rst_req_gnt2", {31'd0, gnt0}, 0);

        // Full operand sweep on port 0
        for (int v = 0; v < 256; v++) begin
            run_job(1'b0, v[7:0], ref_sqrt(v), "sweep");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
